emb_argmax: RTL and testbench

Character decoder for the output end of the network: the inverse direction of the embedding layer. Takes, for each of `N` sequence positions, a vector of `CHAR_NUM` signed fixed-point scores and returns the index of the largest score as a `CHAR_LEN`-bit character code. It sits after the final dense layer and drives the same character-index format the embedding layer consumes. Search is serial over the vocabulary, one index per cycle, with all `N` rows compared in parallel.

---
 rtl/emb_argmax.sv | 187 ++++++++++++++++++
 tb/tb_emb_argmax.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/emb_argmax.sv
// -----------------------------------------------------------------------------
// emb_argmax -- character decoder at the output end of the network.
//
// For each of N sequence positions, takes CHAR_NUM signed fixed-point scores
// and returns the index of the largest score as a CHAR_LEN-bit character code
// (the same index format the embedding layer consumes). The vocabulary is
// scanned serially, one index per cycle, with all N rows compared in parallel.
// Ties resolve to the lowest index because the compare is strict.
//
// Ports:
//   clk    in   1               rising-edge clock
//   rst_n  in   1               synchronous reset, ACTIVE-HIGH despite the name
//   run    in   1               level request; high runs/holds, low aborts/releases
//   d      in   N*CHAR_NUM*N_LEN scores; row i, index k at (i*CHAR_NUM+k)*N_LEN
//   valid  out  1               result ready (registered)
//   q      out  N*CHAR_LEN      winning indices; row i at q[i*CHAR_LEN +: CHAR_LEN]
//   score  out  N*N_LEN         winning scores, row i at i*N_LEN
//                               (only with EMB_ARGMAX_SCORE_EN defined)
//
// Configuration macro: EMB_ARGMAX_SCORE_EN -- adds the registered `score`
// output. Undefined by default; best values then stay internal.
// -----------------------------------------------------------------------------
module emb_argmax #(
  parameter int N        = 10,
  parameter int CHAR_NUM = 200,
  parameter int CHAR_LEN = 8,
  parameter int N_LEN    = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         run,
  input  logic [N*CHAR_NUM*N_LEN-1:0]  d,
  output logic                         valid,
  output logic [N*CHAR_LEN-1:0]        q
`ifdef EMB_ARGMAX_SCORE_EN
  ,
  output logic [N*N_LEN-1:0]           score
`endif
);

  localparam logic [CHAR_LEN-1:0] K_LAST = CHAR_LEN'(CHAR_NUM - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                     r_state;
  state_t                     w_state_nxt;
  logic [CHAR_LEN-1:0]        r_k;
  logic                       r_valid;
  logic [N*CHAR_LEN-1:0]      r_q;

  // Captured copy of d; d itself is not looked at after the capture edge.
  logic signed [N_LEN-1:0]    r_buf      [N][CHAR_NUM];
  logic signed [N_LEN-1:0]    r_best_val [N];
  logic [CHAR_LEN-1:0]        r_best_idx [N];

  logic                       w_capture;
  logic                       w_done;
  logic signed [N_LEN-1:0]    w_cur      [N];
  logic signed [N_LEN-1:0]    w_new_val  [N];
  logic [CHAR_LEN-1:0]        w_new_idx  [N];

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    w_done      = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (run) begin
          w_capture   = 1'b1;
          w_state_nxt = S_SCAN;
        end
      end
      S_SCAN: begin
        // Abort wins over completion on the last scan edge.
        if (!run) begin
          w_state_nxt = S_IDLE;
        end else if (r_k == K_LAST) begin
          w_done      = 1'b1;
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        if (!run) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Per-row compare of score[k] against the running best (strict, signed)
  // ---------------------------------------------------------------------------
  always_comb begin
    for (int i = 0; i < N; i++) begin
      w_cur[i]     = r_buf[i][r_k];
      w_new_val[i] = r_best_val[i];
      w_new_idx[i] = r_best_idx[i];
      if (w_cur[i] > r_best_val[i]) begin
        w_new_val[i] = w_cur[i];
        w_new_idx[i] = r_k;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Score buffer and running best: contents are don't-care after reset
  // ---------------------------------------------------------------------------
  // NOTE: the buffer and running-best registers are deliberately not reset;
  // they are always written on the capture edge before anything reads them,
  // and leaving them out of reset keeps the wide buffer a plain register file.
  always_ff @(posedge clk) begin
    if (w_capture) begin
      for (int i = 0; i < N; i++) begin
        for (int k = 0; k < CHAR_NUM; k++) begin
          r_buf[i][k] <= d[(i*CHAR_NUM + k)*N_LEN +: N_LEN];
        end
        r_best_val[i] <= d[(i*CHAR_NUM)*N_LEN +: N_LEN];
        r_best_idx[i] <= '0;
      end
    end else if (r_state == S_SCAN) begin
      for (int i = 0; i < N; i++) begin
        r_best_val[i] <= w_new_val[i];
        r_best_idx[i] <= w_new_idx[i];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Control state, index counter and registered outputs
  // ---------------------------------------------------------------------------
`ifdef EMB_ARGMAX_SCORE_EN
  logic [N*N_LEN-1:0] r_score;
  assign score = r_score;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_state <= S_IDLE;
      r_k     <= '0;
      r_valid <= 1'b0;
      r_q     <= '0;
`ifdef EMB_ARGMAX_SCORE_EN
      r_score <= '0;
`endif
    end else begin
      r_state <= w_state_nxt;
      unique case (r_state)
        S_IDLE: begin
          // Index 0 seeds the running best, so the scan starts at 1.
          if (w_capture) r_k <= CHAR_LEN'(1);
        end
        S_SCAN: begin
          if (!run || r_k == K_LAST) r_k <= '0;
          else                       r_k <= r_k + CHAR_LEN'(1);
          if (w_done) begin
            // Results include this edge's compare of the last index.
            r_valid <= 1'b1;
            for (int i = 0; i < N; i++) begin
              r_q[i*CHAR_LEN +: CHAR_LEN] <= w_new_idx[i];
`ifdef EMB_ARGMAX_SCORE_EN
              r_score[i*N_LEN +: N_LEN]   <= w_new_val[i];
`endif
            end
          end
        end
        S_DONE: begin
          if (!run) r_valid <= 1'b0;
        end
        default: r_valid <= 1'b0;
      endcase
    end
  end

  assign valid = r_valid;
  assign q     = r_q;

endmodule

// File: tb/tb_emb_argmax.sv
// -----------------------------------------------------------------------------
// tb_emb_argmax -- self-checking bench for emb_argmax.
// Scores are held as a plain 2-D array; the expected index per row is the
// first position holding the row maximum, found by a straightforward search.
// -----------------------------------------------------------------------------
module tb_emb_argmax;

  localparam int N        = 10;
  localparam int CHAR_NUM = 200;
  localparam int CHAR_LEN = 8;
  localparam int N_LEN    = 16;

  logic                        clk;
  logic                        rst_n;
  logic                        run;
  logic [N*CHAR_NUM*N_LEN-1:0] d;
  logic                        valid;
  logic [N*CHAR_LEN-1:0]       q;
`ifdef EMB_ARGMAX_SCORE_EN
  logic [N*N_LEN-1:0]          score;
`endif

  emb_argmax #(
    .N        (N),
    .CHAR_NUM (CHAR_NUM),
    .CHAR_LEN (CHAR_LEN),
    .N_LEN    (N_LEN)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .run   (run),
    .d     (d),
    .valid (valid),
    .q     (q)
`ifdef EMB_ARGMAX_SCORE_EN
    ,
    .score (score)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic signed [N_LEN-1:0] sc [N][CHAR_NUM];
  logic [N*CHAR_LEN-1:0]   exp_q;
  logic [N*N_LEN-1:0]      exp_score;

  task automatic check(input string tag, input logic [255:0] got,
                       input logic [255:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock edge, then settle so outputs are sampled away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pack_d();
    for (int i = 0; i < N; i++)
      for (int k = 0; k < CHAR_NUM; k++)
        d[(i*CHAR_NUM + k)*N_LEN +: N_LEN] = sc[i][k];
  endtask

  // Reference: first index holding the row maximum.
  task automatic model();
    for (int i = 0; i < N; i++) begin
      int best;
      best = 0;
      for (int k = 1; k < CHAR_NUM; k++)
        if (sc[i][k] > sc[i][best]) best = k;
      exp_q[i*CHAR_LEN +: CHAR_LEN] = CHAR_LEN'(best);
      exp_score[i*N_LEN +: N_LEN]   = sc[i][best];
    end
  endtask

  task automatic fill_const(input int row, input int val);
    for (int k = 0; k < CHAR_NUM; k++) sc[row][k] = N_LEN'(val);
  endtask

  task automatic fill_random(input int row, input bit narrow);
    for (int k = 0; k < CHAR_NUM; k++)
      if (narrow) sc[row][k] = N_LEN'(int'($urandom_range(0, 4)) - 2);
      else        sc[row][k] = N_LEN'($urandom);
  endtask

  // Full job: capture, wait for valid, check result and latency.
  task automatic run_job(input string tag, input bit scramble,
                         input bit release_after);
    int lat;
    pack_d();
    model();
    run = 1'b1;
    step();                          // capture edge E0
    check({tag, ":valid_after_capture"}, valid, 1'b0);
    if (scramble)
      for (int w = 0; w < N*CHAR_NUM; w++) d[w*N_LEN +: N_LEN] = N_LEN'($urandom);
    lat = 0;
    while (!valid && lat < CHAR_NUM + 10) begin
      if (scramble) d = ~d;
      step();
      lat++;
    end
    check({tag, ":latency"}, lat, CHAR_NUM - 1);
    check({tag, ":q"}, q, exp_q);
`ifdef EMB_ARGMAX_SCORE_EN
    check({tag, ":score"}, score, exp_score);
`endif
    if (release_after) begin
      repeat (3) step();
      check({tag, ":valid_hold"}, valid, 1'b1);
      check({tag, ":q_hold"}, q, exp_q);
      run = 1'b0;
      step();
      check({tag, ":valid_fall"}, valid, 1'b0);
      check({tag, ":q_after_release"}, q, exp_q);
    end
  endtask

  initial begin
    bit seen_valid;
    rst_n = 1'b1;
    run   = 1'b0;
    d     = '0;

    // Reset state.
    step();
    step();
    check("reset:valid", valid, 1'b0);
    check("reset:q", q, '0);
`ifdef EMB_ARGMAX_SCORE_EN
    check("reset:score", score, '0);
`endif
    rst_n = 1'b0;
    step();

    // Row i: 100 at index 3*i+5, zero elsewhere.
    for (int i = 0; i < N; i++) begin
      fill_const(i, 0);
      sc[i][3*i + 5] = 16'sd100;
    end
    run_job("diag", 1'b0, 1'b1);

    // Tie: row 0 has 0x7FFF at 7 and 150; other rows all -1.
    fill_const(0, 0);
    sc[0][7]   = 16'sh7FFF;
    sc[0][150] = 16'sh7FFF;
    for (int i = 1; i < N; i++) fill_const(i, -1);
    run_job("tie", 1'b0, 1'b1);

    // All negative row 2: -32768 everywhere except -1 at the last index.
    for (int i = 0; i < N; i++) fill_random(i, 1'b0);
    fill_const(2, -32768);
    sc[2][CHAR_NUM-1] = -16'sd1;
    run_job("neg", 1'b0, 1'b1);

    // Abort at scan cycle 50: valid never rises, q keeps the previous job.
    for (int i = 0; i < N; i++) fill_random(i, 1'b0);
    pack_d();
    run = 1'b1;
    step();
    seen_valid = 1'b0;
    repeat (50) begin
      step();
      if (valid) seen_valid = 1'b1;
    end
    run = 1'b0;
    repeat (CHAR_NUM + 20) begin
      step();
      if (valid) seen_valid = 1'b1;
    end
    check("abort:valid_never", seen_valid, 1'b0);
    check("abort:q_kept", q, exp_q);

    // New job after abort with different data.
    for (int i = 0; i < N; i++) fill_random(i, 1'b1);
    run_job("post_abort", 1'b0, 1'b1);

    // d scrambled every cycle after capture.
    for (int i = 0; i < N; i++) fill_random(i, 1'b0);
    run_job("scramble", 1'b1, 1'b1);

    // Random jobs, wide and narrow value ranges (narrow forces ties).
    for (int j = 0; j < 4; j++) begin
      for (int i = 0; i < N; i++) fill_random(i, j[0]);
      run_job($sformatf("rand%0d", j), 1'b0, 1'b1);
    end

    // Reset while in DONE with run still high.
    for (int i = 0; i < N; i++) fill_random(i, 1'b0);
    run_job("pre_rst", 1'b0, 1'b0);
    rst_n = 1'b1;
    step();
    check("rst_done:valid", valid, 1'b0);
    check("rst_done:q", q, '0);
`ifdef EMB_ARGMAX_SCORE_EN
    check("rst_done:score", score, '0);
`endif
    rst_n = 1'b0;
    for (int i = 0; i < N; i++) fill_random(i, 1'b1);
    run_job("post_rst", 1'b0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
